dm_sba_engine: RTL and testbench
================================

# dm_sba_engine

Parametrised system-bus-access engine for the debug module. It replaces the fixed 32-bit SBA path with a BusWidth-generic master that supports 8/16/32/64-bit accesses, address auto-increment, read-on-address and read-on-data modes, byte-lane steering, busy-error detection and an optional bus timeout. It sits between the DM CSR file (sbcs/sbaddress/sbdata decode) and the system interconnect.

## Interface
- BusWidth, 32, bus address/data width; 32 or 64.
- TimeoutCycles, 255, cycles a transaction may stall before the timeout fires (only with DM_SBA_TIMEOUT_EN).

- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- dmactive_i  in  1  low: synchronous clear to Idle, address/error/data cleared
- sbaddress_i  in  BusWidth  new address value
- sbaddress_write_valid_i  in  1  load address register
- sbreadonaddr_i / sbreadondata_i / sbautoincrement_i  in  1 each  sbcs mode bits
- sbaccess_i  in  3  access size code (0=8b ... 3=64b)
- sbdata_i  in  BusWidth  write data
- sbdata_write_valid_i / sbdata_read_valid_i  in  1 each  DMI wrote/read sbdata0
- sbaddress_o  out  BusWidth  current address register
- sbdata_o  out  BusWidth  read data, right-aligned, zero-extended
- sbdata_valid_o  out  1  one-cycle pulse, sbdata_o updated
- sbbusy_o  out  1  state != Idle
- sbbusyerror_o  out  1  one-cycle pulse, trigger received while busy
- sberror_valid_o  out  1  one-cycle pulse, sberror_o valid
- sberror_o  out  3  1 timeout, 2 bus error, 3 misaligned, 4 unsupported size
- master_req_o, master_we_o  out  1
- master_add_o  out  BusWidth
- master_wdata_o  out  BusWidth
- master_be_o  out  BusWidth/8
- master_gnt_i, master_r_valid_i, master_r_err_i  in  1
- master_r_rdata_i  in  BusWidth

## Operation
- FSM states Idle, Read, Write, WaitRead, WaitWrite (sba_state_e encoding).
- Idle triggers, priority order: (1) sbaddress_write_valid_i && sbreadonaddr_i -> Read, using new address; (2) sbdata_write_valid_i -> Write; (3) sbdata_read_valid_i && sbreadondata_i -> Read. Lower-priority simultaneous triggers dropped, sbbusyerror_o pulses.
- Address register loads on sbaddress_write_valid_i in Idle only; while busy the write is ignored and sbbusyerror_o pulses. Any trigger while busy: ignored plus sbbusyerror_o.
- Trigger checks: size > BusWidth -> sberror 4; address not multiple of 2^sbaccess -> sberror 3. No bus access, stay Idle, sberror_valid_o pulses.
- Read/Write: master_req_o=1, master_add_o=address, be = ((1<<(1<<sbaccess))-1) << addr[log2(BusWidth/8)-1:0], wdata = sbdata_i << 8*offset (sbdata_i latched at trigger). Held stable until master_gnt_i; gnt -> WaitRead/WaitWrite.
- WaitRead on master_r_valid_i: sbdata_o <= (rdata >> 8*offset) masked to size; sbdata_valid_o pulse. WaitWrite on master_r_valid_i: done. Either: r_err -> sberror 2 (data still presented for reads), return Idle.
- Auto-increment: on error-free completion with sbautoincrement_i, address += 2^sbaccess modulo 2^BusWidth (wraps to 0).
- master_r_valid_i in Idle/Read/Write ignored (late responses after timeout discarded).

## Timing
- Reset: all outputs 0; state Idle; address 0.
- Trigger at cycle 0 -> master_req_o cycle 1; gnt in cycle 1 -> WaitRead cycle 2; r_valid cycle 2 -> sbdata_valid_o cycle 3. Min trigger-to-data latency 3 cycles. sbbusy_o high cycles 1-2.
- sberror_valid_o/sbdata_valid_o/sbbusyerror_o are registered, one cycle wide.
- dmactive_i low or rst_ni mid-transaction: req dropped next cycle (async for rst_ni), Idle.

## Configuration
- DM_SBA_TIMEOUT_EN defined: counter runs in Read/Write/WaitRead/WaitWrite, reset on every state change; reaching TimeoutCycles -> Idle, master_req_o low, sberror 1, no increment.
- Undefined: no counter, engine waits indefinitely; sberror 1 never produced.

## Test plan
- BusWidth=32, addr 0x1002, sbaccess=1, readonaddr; gnt immediate, rdata 0xABCD1234 -> be=0b1100, sbdata_o=0x0000ABCD at cycle 3.
- Write sbaccess=0, addr 0x3, sbdata 0x5A, autoincrement -> wdata=0x5A000000, be=0b1000, sbaddress_o=0x4 after r_valid.
- Autoincrement sbaccess=2 at addr 0xFFFFFFFC -> sbaddress_o wraps to 0x0.
- Addr 0x1001, sbaccess=2 -> sberror 3, master_req_o never asserts; sbaccess=3 on BusWidth=32 -> sberror 4.
- sbdata_write_valid_i while WaitRead -> sbbusyerror_o pulse, no second request; r_err=1 -> sberror 2.
- With DM_SBA_TIMEOUT_EN, TimeoutCycles=8, gnt held low -> sberror 1 after 8 cycles, Idle; late r_valid ignored.

Source files
------------

// File: rtl/dm_sba_engine.sv
// System-bus-access master for the debug module: 8..64-bit accesses, lane steering,
// auto-increment and busy/error reporting. Optional bus timeout: DM_SBA_TIMEOUT_EN.
module dm_sba_engine #(
  parameter int unsigned BusWidth      = 32,
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  dmactive_i,
  input  logic [BusWidth-1:0]   sbaddress_i,
  input  logic                  sbaddress_write_valid_i,
  input  logic                  sbreadonaddr_i,
  input  logic                  sbreadondata_i,
  input  logic                  sbautoincrement_i,
  input  logic [2:0]            sbaccess_i,
  input  logic [BusWidth-1:0]   sbdata_i,
  input  logic                  sbdata_write_valid_i,
  input  logic                  sbdata_read_valid_i,
  output logic [BusWidth-1:0]   sbaddress_o,
  output logic [BusWidth-1:0]   sbdata_o,
  output logic                  sbdata_valid_o,
  output logic                  sbbusy_o,
  output logic                  sbbusyerror_o,
  output logic                  sberror_valid_o,
  output logic [2:0]            sberror_o,
  output logic                  master_req_o,
  output logic                  master_we_o,
  output logic [BusWidth-1:0]   master_add_o,
  output logic [BusWidth-1:0]   master_wdata_o,
  output logic [BusWidth/8-1:0] master_be_o,
  input  logic                  master_gnt_i,
  input  logic                  master_r_valid_i,
  input  logic                  master_r_err_i,
  input  logic [BusWidth-1:0]   master_r_rdata_i
);
  localparam int unsigned ByteW = BusWidth / 8;
  localparam int unsigned OffW  = $clog2(ByteW);
  localparam logic [BusWidth-1:0] AddrOne = {{(BusWidth-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    Idle      = 3'd0,
    Read      = 3'd1,
    Write     = 3'd2,
    WaitRead  = 3'd3,
    WaitWrite = 3'd4
  } sba_state_e;

  function automatic logic [ByteW-1:0] lane_mask(input logic [2:0] acc, input logic [OffW-1:0] off);
    logic [ByteW-1:0] m;
    int unsigned o;
    int unsigned n;
    m = '0;
    o = 32'(off);
    n = 32'd1 << acc;
    for (int unsigned i = 0; i < ByteW; i++) m[i] = (i >= o) && (i < o + n);
    return m;
  endfunction

  function automatic logic [BusWidth-1:0] data_mask(input logic [2:0] acc);
    logic [BusWidth-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < BusWidth; i++) m[i] = (i < (32'd8 << acc));
    return m;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] acc, input logic [OffW-1:0] off);
    return (32'(off) & ((32'd1 << acc) - 32'd1)) != 32'd0;
  endfunction

  sba_state_e          state_r, state_n_s;
  logic [BusWidth-1:0] addr_r, addr_n_s, addr_eff_s;
  logic [2:0]          acc_r, acc_n_s;
  logic                inc_r, inc_n_s;
  logic [ByteW-1:0]    be_r, be_n_s;
  logic [BusWidth-1:0] wdata_r, wdata_n_s, rdata_r, rdata_n_s;
  logic                rvalid_r, rvalid_n_s, busyerr_r, busyerr_n_s;
  logic                err_valid_r, err_valid_n_s;
  logic [2:0]          err_r, err_n_s;
  logic                req_r, we_r, busy_r;
  logic                trig_addr_s, trig_wdata_s, trig_rdata_s, any_trig_s, multi_trig_s;
  logic                size_ok_s, timeout_s;
  logic [OffW-1:0]     off_eff_s;

  assign trig_addr_s  = sbaddress_write_valid_i & sbreadonaddr_i;
  assign trig_wdata_s = sbdata_write_valid_i;
  assign trig_rdata_s = sbdata_read_valid_i & sbreadondata_i;
  assign any_trig_s   = trig_addr_s | trig_wdata_s | trig_rdata_s;
  assign multi_trig_s = (trig_addr_s & trig_wdata_s) | (trig_addr_s & trig_rdata_s) |
                        (trig_wdata_s & trig_rdata_s);
  assign addr_eff_s   = sbaddress_write_valid_i ? sbaddress_i : addr_r;
  assign off_eff_s    = addr_eff_s[OffW-1:0];
  assign size_ok_s    = (32'd8 << sbaccess_i) <= BusWidth;

`ifdef DM_SBA_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TimeoutCycles + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCycles - 1);
  logic [TmoW-1:0] tmo_cnt_r;

  assign timeout_s = (state_r != Idle) && (tmo_cnt_r == TmoLast);

  // Stall counter, restarted whenever the FSM changes state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_cnt_r <= '0;
    end else if (!dmactive_i || (state_n_s != state_r) || (state_r == Idle)) begin
      tmo_cnt_r <= '0;
    end else begin
      tmo_cnt_r <= tmo_cnt_r + TmoW'(1);
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state, trigger qualification and completion handling
  always_comb begin
    state_n_s     = state_r;
    addr_n_s      = addr_r;
    acc_n_s       = acc_r;
    inc_n_s       = inc_r;
    be_n_s        = be_r;
    wdata_n_s     = wdata_r;
    rdata_n_s     = rdata_r;
    rvalid_n_s    = 1'b0;
    busyerr_n_s   = 1'b0;
    err_valid_n_s = 1'b0;
    err_n_s       = err_r;
    case (state_r)
      Idle: begin
        addr_n_s    = addr_eff_s;
        busyerr_n_s = multi_trig_s;
        if (!any_trig_s) begin
          state_n_s = Idle;
        end else if (!size_ok_s) begin
          err_valid_n_s = 1'b1;
          err_n_s       = 3'd4;
        end else if (is_misaligned(sbaccess_i, off_eff_s)) begin
          err_valid_n_s = 1'b1;
          err_n_s       = 3'd3;
        end else begin
          acc_n_s   = sbaccess_i;
          inc_n_s   = sbautoincrement_i;
          be_n_s    = lane_mask(sbaccess_i, off_eff_s);
          wdata_n_s = sbdata_i << {off_eff_s, 3'b000};
          if (trig_addr_s) state_n_s = Read;
          else if (trig_wdata_s) state_n_s = Write;
          else state_n_s = Read;
        end
      end
      Read, Write: begin
        busyerr_n_s = sbaddress_write_valid_i | sbdata_write_valid_i | trig_rdata_s;
        if (master_gnt_i) begin
          state_n_s = (state_r == Read) ? WaitRead : WaitWrite;
        end else if (timeout_s) begin
          state_n_s     = Idle;
          err_valid_n_s = 1'b1;
          err_n_s       = 3'd1;
        end else begin
          state_n_s = state_r;
        end
      end
      WaitRead, WaitWrite: begin
        busyerr_n_s = sbaddress_write_valid_i | sbdata_write_valid_i | trig_rdata_s;
        if (master_r_valid_i) begin
          state_n_s = Idle;
          if (state_r == WaitRead) begin
            rdata_n_s  = (master_r_rdata_i >> {addr_r[OffW-1:0], 3'b000}) & data_mask(acc_r);
            rvalid_n_s = 1'b1;
          end else begin
            rvalid_n_s = 1'b0;
          end
          if (master_r_err_i) begin
            err_valid_n_s = 1'b1;
            err_n_s       = 3'd2;
          end else if (inc_r) begin
            addr_n_s = addr_r + (AddrOne << acc_r);
          end else begin
            addr_n_s = addr_r;
          end
        end else if (timeout_s) begin
          state_n_s     = Idle;
          err_valid_n_s = 1'b1;
          err_n_s       = 3'd1;
        end else begin
          state_n_s = state_r;
        end
      end
      default: begin
        state_n_s = Idle;
      end
    endcase
  end

  // State and output registers; dmactive low acts as a synchronous clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni || !dmactive_i) begin
      state_r     <= Idle;
      addr_r      <= '0;
      acc_r       <= 3'd0;
      inc_r       <= 1'b0;
      be_r        <= '0;
      wdata_r     <= '0;
      rdata_r     <= '0;
      rvalid_r    <= 1'b0;
      busyerr_r   <= 1'b0;
      err_valid_r <= 1'b0;
      err_r       <= 3'd0;
      req_r       <= 1'b0;
      we_r        <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_n_s;
      addr_r      <= addr_n_s;
      acc_r       <= acc_n_s;
      inc_r       <= inc_n_s;
      be_r        <= be_n_s;
      wdata_r     <= wdata_n_s;
      rdata_r     <= rdata_n_s;
      rvalid_r    <= rvalid_n_s;
      busyerr_r   <= busyerr_n_s;
      err_valid_r <= err_valid_n_s;
      err_r       <= err_n_s;
      req_r       <= (state_n_s == Read) || (state_n_s == Write);
      we_r        <= (state_n_s == Write);
      busy_r      <= (state_n_s != Idle);
    end
  end

  assign sbaddress_o     = addr_r;
  assign sbdata_o        = rdata_r;
  assign sbdata_valid_o  = rvalid_r;
  assign sbbusy_o        = busy_r;
  assign sbbusyerror_o   = busyerr_r;
  assign sberror_valid_o = err_valid_r;
  assign sberror_o       = err_r;
  assign master_req_o    = req_r;
  assign master_we_o     = we_r;
  assign master_add_o    = addr_r;
  assign master_wdata_o  = wdata_r;
  assign master_be_o     = be_r;
endmodule

// File: tb/tb_dm_sba_engine.sv
// Randomized self-checking bench for dm_sba_engine (BusWidth=32) against an
// arithmetic transaction-level model.
module tb_dm_sba_engine;
  localparam int unsigned TMO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dmactive = 1'b1;
  logic [31:0] sbaddress = 32'd0;
  logic        addr_wv = 1'b0, ronaddr = 1'b0, rondata = 1'b0, autoinc = 1'b0;
  logic [2:0]  sbaccess = 3'd0;
  logic [31:0] sbdata_in = 32'd0;
  logic        data_wv = 1'b0, data_rv = 1'b0;
  logic [31:0] sbaddress_q, sbdata_q, m_add, m_wdata;
  logic        sbdata_valid, sbbusy, sbbusyerror, sberror_valid, m_req, m_we;
  logic [2:0]  sberror;
  logic [3:0]  m_be;
  logic        gnt = 1'b0, r_valid = 1'b0, r_err = 1'b0;
  logic [31:0] r_rdata = 32'd0;

  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] m_addr = 32'd0;

  always #5 clk = ~clk;

  dm_sba_engine #(.BusWidth(32), .TimeoutCycles(TMO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .dmactive_i(dmactive),
    .sbaddress_i(sbaddress), .sbaddress_write_valid_i(addr_wv),
    .sbreadonaddr_i(ronaddr), .sbreadondata_i(rondata), .sbautoincrement_i(autoinc),
    .sbaccess_i(sbaccess), .sbdata_i(sbdata_in),
    .sbdata_write_valid_i(data_wv), .sbdata_read_valid_i(data_rv),
    .sbaddress_o(sbaddress_q), .sbdata_o(sbdata_q), .sbdata_valid_o(sbdata_valid),
    .sbbusy_o(sbbusy), .sbbusyerror_o(sbbusyerror),
    .sberror_valid_o(sberror_valid), .sberror_o(sberror),
    .master_req_o(m_req), .master_we_o(m_we), .master_add_o(m_add),
    .master_wdata_o(m_wdata), .master_be_o(m_be),
    .master_gnt_i(gnt), .master_r_valid_i(r_valid), .master_r_err_i(r_err),
    .master_r_rdata_i(r_rdata)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_trig();
    addr_wv = 1'b0; ronaddr = 1'b0; rondata = 1'b0; data_wv = 1'b0; data_rv = 1'b0;
  endtask

  // kind: 0 read-on-address, 1 write, 2 read-on-data
  task automatic run_txn(input int kind, input logic [2:0] acc, input logic [31:0] addr,
                         input logic [31:0] data, input logic inc, input int gdly,
                         input int rdly, input logic rerr, input logic [31:0] rdat,
                         input logic poke);
    longint unsigned n, off, exp_be, exp_wd, exp_rd, exp_addr;
    int exp_err;
    n        = 64'd1 << acc;
    off      = 64'(addr) % 64'd4;
    exp_err  = (8 * n > 32) ? 4 : ((64'(addr) % n) != 0) ? 3 : 0;
    exp_be   = (((64'd1 << n) - 64'd1) << off) & 64'hF;
    exp_wd   = (64'(data) << (8 * off)) & 64'hFFFF_FFFF;
    exp_rd   = (64'(rdat) >> (8 * off)) & ((64'd1 << (8 * n)) - 64'd1);
    if (kind != 0) begin
      @(negedge clk);
      sbaddress = addr; addr_wv = 1'b1;
      @(negedge clk);
      clr_trig();
      check_eq("addr_load", 64'(sbaddress_q), 64'(addr));
    end
    @(negedge clk);
    sbaccess = acc; autoinc = inc; sbdata_in = data;
    case (kind)
      0:       begin sbaddress = addr; addr_wv = 1'b1; ronaddr = 1'b1; end
      1:       data_wv = 1'b1;
      default: begin data_rv = 1'b1; rondata = 1'b1; end
    endcase
    m_addr = addr;
    @(negedge clk);
    clr_trig();
    if (exp_err != 0) begin
      check_eq("err_valid", 64'(sberror_valid), 64'd1);
      check_eq("err_code", 64'(sberror), 64'(exp_err));
      check_eq("err_noreq", 64'(m_req), 64'd0);
      @(negedge clk);
      check_eq("err_idle", 64'(m_req | sbbusy), 64'd0);
      return;
    end
    check_eq("req", 64'(m_req), 64'd1);
    check_eq("add", 64'(m_add), 64'(addr));
    check_eq("we", 64'(m_we), (kind == 1) ? 64'd1 : 64'd0);
    check_eq("be", 64'(m_be), exp_be);
    if (kind == 1) check_eq("wdata", 64'(m_wdata), exp_wd);
    for (int i = 0; i < gdly; i++) begin
      @(negedge clk);
      check_eq("req_hold", 64'({m_req, sberror_valid, m_be}), 64'({1'b1, 1'b0, exp_be[3:0]}));
    end
    gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0;
    check_eq("wait_state", 64'({m_req, sbbusy}), 64'b01);
    if (poke) begin
      data_wv = 1'b1;
      @(negedge clk);
      data_wv = 1'b0;
      check_eq("busyerr", 64'(sbbusyerror), 64'd1);
      check_eq("no_2nd_req", 64'(m_req), 64'd0);
    end
    for (int i = 0; i < rdly; i++) @(negedge clk);
    r_valid = 1'b1; r_err = rerr; r_rdata = rdat;
    @(negedge clk);
    r_valid = 1'b0; r_err = 1'b0;
    check_eq("data_valid", 64'(sbdata_valid), (kind == 1) ? 64'd0 : 64'd1);
    if (kind != 1) check_eq("rdata", 64'(sbdata_q), exp_rd);
    check_eq("resp_err", 64'(sberror_valid), 64'(rerr));
    if (rerr) check_eq("bus_err_code", 64'(sberror), 64'd2);
    check_eq("idle", 64'(sbbusy), 64'd0);
    exp_addr = (inc && !rerr) ? ((64'(addr) + n) & 64'hFFFF_FFFF) : 64'(addr);
    m_addr = exp_addr[31:0];
    check_eq("addr_after", 64'(sbaddress_q), 64'(m_addr));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_outs", 64'({m_req, m_we, sbbusy, sbdata_valid, sberror_valid, sbbusyerror}), 64'd0);
    check_eq("rst_addr", 64'(sbaddress_q), 64'd0);
    check_eq("rst_data", 64'(sbdata_q), 64'd0);
    rst_n = 1'b1;

    run_txn(0, 3'd1, 32'h0000_1002, 32'd0, 1'b0, 0, 0, 1'b0, 32'hABCD_1234, 1'b0);
    run_txn(1, 3'd0, 32'h0000_0003, 32'h0000_005A, 1'b1, 0, 0, 1'b0, 32'd0, 1'b0);
    run_txn(1, 3'd2, 32'hFFFF_FFFC, 32'h1234_5678, 1'b1, 1, 1, 1'b0, 32'd0, 1'b0);
    run_txn(0, 3'd2, 32'h0000_1001, 32'd0, 1'b0, 0, 0, 1'b0, 32'd0, 1'b0);
    run_txn(0, 3'd3, 32'h0000_1000, 32'd0, 1'b0, 0, 0, 1'b0, 32'd0, 1'b0);
    run_txn(0, 3'd2, 32'h0000_0010, 32'd0, 1'b1, 0, 2, 1'b1, 32'h5555_AAAA, 1'b1);
    run_txn(1, 3'd2, 32'h0000_0080, 32'hCAFE_F00D, 1'b0, 40, 2, 1'b0, 32'd0, 1'b0);

    // Simultaneous read-on-address and data write: write dropped, busy error
    @(negedge clk);
    sbaddress = 32'h100; addr_wv = 1'b1; ronaddr = 1'b1; data_wv = 1'b1;
    sbaccess = 3'd2; autoinc = 1'b0;
    @(negedge clk);
    clr_trig();
    check_eq("multi_busyerr", 64'(sbbusyerror), 64'd1);
    check_eq("multi_read", 64'({m_req, m_we}), 64'b10);
    gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0; r_valid = 1'b1; r_rdata = 32'h1122_3344;
    @(negedge clk);
    r_valid = 1'b0;
    check_eq("multi_rdata", 64'(sbdata_q), 64'h1122_3344);

    // Response while idle is discarded
    r_valid = 1'b1;
    @(negedge clk);
    r_valid = 1'b0;
    check_eq("late_rvalid", 64'({sbdata_valid, sbbusy}), 64'd0);

    // dmactive drop mid-transaction
    sbaddress = 32'h200; addr_wv = 1'b1; ronaddr = 1'b1; sbaccess = 3'd2;
    @(negedge clk);
    clr_trig();
    check_eq("dm_req", 64'(m_req), 64'd1);
    dmactive = 1'b0;
    @(negedge clk);
    dmactive = 1'b1;
    check_eq("dm_clear", 64'({m_req, sbbusy}), 64'd0);
    check_eq("dm_addr", 64'(sbaddress_q), 64'd0);

`ifdef DM_SBA_TIMEOUT_EN
    begin
      int k;
      bit seen;
      k = 0; seen = 1'b0;
      sbaddress = 32'h40; addr_wv = 1'b1; ronaddr = 1'b1; sbaccess = 3'd2;
      for (int c = 1; c <= 30 && !seen; c++) begin
        @(negedge clk);
        clr_trig();
        if (sberror_valid) begin seen = 1'b1; k = c; end
      end
      check_eq("tmo_seen", 64'(seen), 64'd1);
      check_eq("tmo_cycle", 64'(k), 64'(TMO + 1));
      check_eq("tmo_code", 64'(sberror), 64'd1);
      check_eq("tmo_idle", 64'({m_req, sbbusy}), 64'd0);
      r_valid = 1'b1;
      @(negedge clk);
      r_valid = 1'b0;
      check_eq("tmo_late", 64'(sbdata_valid), 64'd0);
      check_eq("tmo_addr", 64'(sbaddress_q), 64'h40);
    end
`endif

    for (int t = 0; t < 80; t++) begin
      int kind;
      logic [2:0] acc;
      logic [31:0] addr;
      kind = $urandom_range(0, 2);
      acc  = 3'($urandom_range(0, 3));
      addr = $urandom;
      if ($urandom_range(0, 7) == 0) addr = 32'hFFFF_FFF8 | addr[2:0];
      if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << acc) - 32'd1);
      run_txn(kind, acc, addr, $urandom, 1'($urandom_range(0, 1)),
              $urandom_range(0, 3), $urandom_range(0, 3),
              ($urandom_range(0, 7) == 0), $urandom, ($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
